// File: rtl/digit_sum_seq.sv
// ---------------------------------------------------------------------------
// digit_sum_seq
//   Sequential digit-sum engine. A WIDTH-bit operand is captured on an
//   accepted start and its radix-2^DIGIT_W digits are summed one per clock,
//   least significant digit first. The loop stops as soon as the remaining
//   digits are all zero. In root mode the sum is fed back through the same
//   loop until it fits in a single digit.
//   This block is shared by the hex-digit-sum, popcount and digital-root
//   functions.
//
// Parameters
//   WIDTH    operand width in bits; must be a multiple of DIGIT_W
//   DIGIT_W  digit width in bits, 1..8 (4 = hex digits, 1 = popcount)
//
// Ports
//   clk    rising-edge clock
//   rst    synchronous active-high reset; aborts any job in flight
//   start  job request, taken only on an edge where ready is high
//   mode   0 = plain digit sum, 1 = digital root (sampled with start)
//   num    operand (sampled with start)
//   ready  high while idle
//   done   one-cycle pulse when sum is updated
//   sum    last result, held until the next done
// ---------------------------------------------------------------------------
module digit_sum_seq #(
    parameter  int WIDTH   = 32,
    parameter  int DIGIT_W = 4,
    localparam int NDIG    = WIDTH / DIGIT_W,
    localparam int SUM_W   = $clog2(NDIG * (2**DIGIT_W - 1) + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] num,
    output logic             ready,
    output logic             done,
    output logic [SUM_W-1:0] sum
);

    // The shift register must hold both the operand and an intermediate sum
    // fed back in root mode.
    localparam int SR_W = (WIDTH > SUM_W) ? WIDTH : SUM_W;

    if ((DIGIT_W < 1) || (DIGIT_W > 8) || ((WIDTH % DIGIT_W) != 0)) begin : g_bad_params
        $error("digit_sum_seq: DIGIT_W must be 1..8 and divide WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t            state_reg;
    logic [SR_W-1:0]   sr_reg;
    logic [SUM_W-1:0]  acc_reg;
    logic              mode_reg;

    assign ready = (state_reg == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            sr_reg    <= '0;
            acc_reg   <= '0;
            mode_reg  <= 1'b0;
            sum       <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        sr_reg    <= SR_W'(num);
                        acc_reg   <= '0;
                        mode_reg  <= mode;
                        state_reg <= ACC;
                    end
                end

                ACC: begin
                    acc_reg <= acc_reg + SUM_W'(sr_reg[DIGIT_W-1:0]);
                    sr_reg  <= sr_reg >> DIGIT_W;
                    // Early exit: nothing non-zero left above the digit
                    // being added this cycle.
                    if ((sr_reg >> DIGIT_W) == '0) begin
                        state_reg <= FIN;
                    end
                end

                FIN: begin
                    // acc_reg is complete here. A value with any bit above
                    // the low digit is still more than one digit wide.
                    if (mode_reg && ((acc_reg >> DIGIT_W) != '0)) begin
                        sr_reg    <= SR_W'(acc_reg);
                        acc_reg   <= '0;
                        state_reg <= ACC;
                    end else begin
                        sum       <= acc_reg;
                        done      <= 1'b1;
                        state_reg <= IDLE;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_digit_sum_seq.sv
// ---------------------------------------------------------------------------
// tb_digit_sum_seq
//   Directed bench for digit_sum_seq. Instance a uses the defaults
//   (WIDTH=32, DIGIT_W=4); instance b is the popcount form (WIDTH=8,
//   DIGIT_W=1). Expected sums and latencies are worked out by hand.
// ---------------------------------------------------------------------------
module tb_digit_sum_seq;

    logic        clk = 1'b0;
    logic        rst;

    logic        start_a, mode_a;
    logic [31:0] num_a;
    logic        ready_a, done_a;
    logic [6:0]  sum_a;

    logic        start_b, mode_b;
    logic [7:0]  num_b;
    logic        ready_b, done_b;
    logic [3:0]  sum_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    digit_sum_seq #(.WIDTH(32), .DIGIT_W(4)) dut_a (
        .clk   (clk),
        .rst   (rst),
        .start (start_a),
        .mode  (mode_a),
        .num   (num_a),
        .ready (ready_a),
        .done  (done_a),
        .sum   (sum_a)
    );

    digit_sum_seq #(.WIDTH(8), .DIGIT_W(1)) dut_b (
        .clk   (clk),
        .rst   (rst),
        .start (start_b),
        .mode  (mode_b),
        .num   (num_b),
        .ready (ready_b),
        .done  (done_b),
        .sum   (sum_b)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    // Launch one job from the current (post-edge) point, wait for done and
    // check the edge count from the accepting edge, the result and that
    // ready stayed low while busy.
    task automatic run_job(input bit use_b, input logic [31:0] n, input bit m,
                           input int exp_sum, input int exp_lat, input string tag);
        int cyc;
        int busy_bad;
        cyc      = 0;
        busy_bad = 0;
        if (use_b) begin
            num_b = n[7:0]; mode_b = m; start_b = 1'b1;
        end else begin
            num_a = n;      mode_a = m; start_a = 1'b1;
        end
        @(posedge clk); #1;
        // Operand and mode are don't-care once accepted: scramble them.
        start_a = 1'b0; start_b = 1'b0;
        num_a   = $urandom; num_b = 8'($urandom);
        mode_a  = ~m;       mode_b = ~m;
        while (((use_b ? done_b : done_a) !== 1'b1) && (cyc < 200)) begin
            if ((use_b ? ready_b : ready_a) !== 1'b0) busy_bad++;
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, " latency"}, cyc, exp_lat);
        check({tag, " sum"}, use_b ? int'(sum_b) : int'(sum_a), exp_sum);
        check({tag, " busy ready"}, busy_bad, 0);
        check({tag, " ready after"}, use_b ? int'(ready_b) : int'(ready_a), 1);
    endtask

    initial begin
        int extra;
        rst = 1'b1;
        start_a = 1'b0; mode_a = 1'b0; num_a = '0;
        start_b = 1'b0; mode_b = 1'b0; num_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset a sum", int'(sum_a), 0);
        check("reset a done", int'(done_a), 0);
        check("reset a ready", int'(ready_a), 1);
        check("reset b sum", int'(sum_b), 0);
        check("reset b ready", int'(ready_b), 1);
        rst = 1'b0;
        @(posedge clk); #1;

        // Hex digit sum: B+F+1+A = 37 over 4 digits.
        run_job(1'b0, 32'h0000A1FB, 1'b0, 37, 5, "a A1FB plain");
        @(posedge clk); #1;
        check("a done pulse width", int'(done_a), 0);
        check("a sum held", int'(sum_a), 37);

        // Root: 37 = 0x25 -> 7.
        run_job(1'b0, 32'h0000A1FB, 1'b1, 7, 8, "a A1FB root");
        run_job(1'b0, 32'hFFFFFFFF, 1'b0, 120, 9, "a FFFFFFFF plain");
        // 120 = 0x78 -> 15.
        run_job(1'b0, 32'hFFFFFFFF, 1'b1, 15, 12, "a FFFFFFFF root");

        // Zero operand, then back-to-back start on the done cycle.
        run_job(1'b0, 32'h00000000, 1'b0, 0, 2, "a zero plain");
        run_job(1'b0, 32'h00000001, 1'b0, 1, 2, "a one b2b");
        run_job(1'b0, 32'h00000000, 1'b1, 0, 2, "a zero root");
        run_job(1'b0, 32'h80000000, 1'b0, 8, 9, "a top digit");

        // Start while busy is neither taken nor queued.
        num_a = 32'h0000000F; mode_a = 1'b0; start_a = 1'b1;
        @(posedge clk); #1;
        num_a = 32'h000000FF; start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        @(posedge clk); #1;
        check("a busy start done", int'(done_a), 1);
        check("a busy start sum", int'(sum_a), 15);
        extra = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done_a === 1'b1) extra++;
        end
        check("a busy start not queued", extra, 0);
        check("a busy start sum kept", int'(sum_a), 15);

        // Popcount instance: 0xB7 has six ones; root 6 -> 2 -> 1.
        run_job(1'b1, 32'h000000B7, 1'b0, 6, 9, "b B7 plain");
        run_job(1'b1, 32'h000000B7, 1'b1, 1, 16, "b B7 root");
        run_job(1'b1, 32'h00000001, 1'b0, 1, 2, "b 01 plain");

        // Reset in the middle of an accumulation aborts the job.
        num_a = 32'hFFFFFFFF; mode_a = 1'b0; start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("a mid-job ready low", int'(ready_a), 0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("a abort ready", int'(ready_a), 1);
        check("a abort sum", int'(sum_a), 0);
        check("a abort done", int'(done_a), 0);
        rst = 1'b0;
        extra = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done_a === 1'b1) extra++;
        end
        check("a abort no done", extra, 0);
        check("a abort sum kept", int'(sum_a), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
